// File: rtl/rtc_time_editor_pkg.sv
// rtc_time_editor_pkg: FSM states, field indices, BCD limits and BCD helpers for rtc_time_editor
package rtc_time_editor_pkg;
  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
  localparam logic [2:0] F_SEG = 3'd0, F_MIN = 3'd1, F_HORA = 3'd2, F_DIA = 3'd3, F_MES = 3'd4, F_ANO = 3'd5;
  localparam logic [2:0] F_TSEG = 3'd0, F_TMIN = 3'd1, F_THORA = 3'd2;
  localparam logic [7:0] LIM_59 = 8'h59, LIM_23 = 8'h23, LIM_12 = 8'h12, LIM_31 = 8'h31, LIM_99 = 8'h99;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    return (v >= hi) ? lo : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    return (v <= lo) ? hi : (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction
  function automatic logic [7:0] to_12h(input logic [7:0] h);
    return (h == 8'h00) ? LIM_12 : (h <= LIM_12) ? h
         : (h[3:0] >= 4'd2) ? {h[7:4] - 4'd1, h[3:0] - 4'd2} : {h[7:4] - 4'd2, h[3:0] + 4'd8};
  endfunction
endpackage

// File: rtl/rtc_time_editor_btn_debounce.sv
// btn_debounce: 2-FF synchronizer and stable-level debouncer emitting a one-cycle press strobe
module btn_debounce #(
  parameter int DEB_CYC = 1000000
) (
  input  logic CLK,
  input  logic Reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEB_CYC + 1);
  logic s1, s2, level;
  logic [CW-1:0] cnt;
  // accept a new level only after DEB_CYC consecutive differing samples; strobe on accepted rise
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      press <= 1'b0;
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(DEB_CYC - 1)) begin
        level <= s2;
        cnt <= '0;
        press <= s2;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/rtc_time_editor.sv
// rtc_time_editor: push-button BCD editor for RTC clock/date/timer fields; define MONTH_DAYS_EN for month-aware day limits
module rtc_time_editor
  import rtc_time_editor_pkg::*;
#(
  parameter int DEB_CYC = 1000000,
  parameter int WR_PULSE_CYC = 4,
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_commit,
  input  logic       CT,
  input  logic       doce_24,
  output logic [7:0] clk_seg,
  output logic [7:0] clk_min,
  output logic [7:0] clk_hora,
  output logic [7:0] Dia,
  output logic [7:0] Mes,
  output logic [7:0] Ano,
  output logic [7:0] T_seg,
  output logic [7:0] T_min,
  output logic [7:0] T_hora,
  output logic [2:0] cursor,
  output logic       edit_active,
  output logic       WR
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int WW = $clog2(WR_PULSE_CYC + 1);
  state_t state, state_n;
  logic su, sd, sl, sr, sc, any_dir, any_s, upd, inc, dec, ml, mr, we, ct_q, d24_q;
  logic [TW-1:0] icnt;
  logic [WW-1:0] wcnt;
  logic [7:0] cur, lo, hi, nv, dia_hi;
  logic [5:0] wc;
  logic [2:0] wt, cmax;
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_up (.CLK(CLK), .Reset(Reset), .btn(btn_up), .press(su));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_down (.CLK(CLK), .Reset(Reset), .btn(btn_down), .press(sd));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_left (.CLK(CLK), .Reset(Reset), .btn(btn_left), .press(sl));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_right (.CLK(CLK), .Reset(Reset), .btn(btn_right), .press(sr));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_commit (.CLK(CLK), .Reset(Reset), .btn(btn_commit), .press(sc));
`ifdef MONTH_DAYS_EN
  logic [1:0] ano_m4;
  // day limit follows month length, February gains a day when the year is divisible by four
  always_comb begin
    ano_m4 = {Ano[4], 1'b0} + Ano[1:0];
    dia_hi = (Mes == 8'h02) ? ((ano_m4 == 2'd0) ? 8'h29 : 8'h28)
           : (Mes == 8'h04 || Mes == 8'h06 || Mes == 8'h09 || Mes == 8'h11) ? 8'h30 : LIM_31;
  end
`else
  assign dia_hi = LIM_31;
`endif
  // strobe qualification, selected field, its range and the BCD step result
  always_comb begin
    any_dir = su | sd | sl | sr;
    any_s = any_dir | sc;
    upd = state == EDIT && !sc;
    inc = upd && su && !sd;
    dec = upd && sd && !su;
    mr = upd && sr && !sl;
    ml = upd && sl && !sr;
    cmax = CT ? F_ANO : F_THORA;
    we = (inc || dec) && (CT || cursor <= F_THORA);
    wc = (we && CT) ? 6'd1 << cursor : 6'd0;
    wt = (we && !CT) ? 3'd1 << cursor : 3'd0;
    cur = !CT ? ((cursor == F_TSEG) ? T_seg : (cursor == F_TMIN) ? T_min : T_hora)
        : (cursor == F_SEG) ? clk_seg : (cursor == F_MIN) ? clk_min : (cursor == F_HORA) ? clk_hora
        : (cursor == F_DIA) ? Dia : (cursor == F_MES) ? Mes : Ano;
    lo = (CT && (cursor == F_DIA || cursor == F_MES || (cursor == F_HORA && doce_24))) ? 8'h01 : 8'h00;
    hi = !CT ? ((cursor == F_THORA) ? LIM_23 : LIM_59)
       : (cursor == F_HORA) ? (doce_24 ? LIM_12 : LIM_23) : (cursor == F_DIA) ? dia_hi
       : (cursor == F_MES) ? LIM_12 : (cursor == F_ANO) ? LIM_99 : LIM_59;
    nv = inc ? bcd_inc(cur, lo, hi) : bcd_dec(cur, lo, hi);
  end
  // next state and status outputs
  always_comb begin
    edit_active = state == EDIT;
    WR = state == COMMIT;
    state_n = (state == IDLE) ? (any_dir ? EDIT : IDLE)
            : (state == EDIT) ? (sc ? COMMIT : (!any_s && icnt == TW'(TIMEOUT_CYC - 1)) ? IDLE : EDIT)
            : (wcnt == WW'(WR_PULSE_CYC - 1)) ? IDLE : COMMIT;
  end
  // state register
  always_ff @(posedge CLK) begin
    if (!Reset) state <= IDLE;
    else state <= state_n;
  end
  // inactivity and write-pulse counters
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      icnt <= '0;
      wcnt <= '0;
    end else begin
      icnt <= (state == EDIT && !any_s) ? icnt + TW'(1) : '0;
      wcnt <= (state == COMMIT) ? wcnt + WW'(1) : '0;
    end
  end
  // working field copies, cursor, 12 h coercion and day clamping
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      clk_seg <= 8'h00;
      clk_min <= 8'h00;
      clk_hora <= 8'h12;
      Dia <= 8'h01;
      Mes <= 8'h01;
      Ano <= 8'h00;
      T_seg <= 8'h00;
      T_min <= 8'h00;
      T_hora <= 8'h00;
      cursor <= 3'd0;
      ct_q <= CT;
      d24_q <= doce_24;
    end else begin
      ct_q <= CT;
      d24_q <= doce_24;
      cursor <= (CT != ct_q) ? 3'd0 : mr ? ((cursor >= cmax) ? 3'd0 : cursor + 3'd1)
              : ml ? ((cursor == 3'd0) ? cmax : cursor - 3'd1) : cursor;
      clk_seg <= wc[F_SEG] ? nv : clk_seg;
      clk_min <= wc[F_MIN] ? nv : clk_min;
      clk_hora <= (doce_24 && !d24_q) ? to_12h(clk_hora) : wc[F_HORA] ? nv : clk_hora;
`ifdef MONTH_DAYS_EN
      Dia <= (Dia > dia_hi) ? dia_hi : wc[F_DIA] ? nv : Dia;
`else
      Dia <= wc[F_DIA] ? nv : Dia;
`endif
      Mes <= wc[F_MES] ? nv : Mes;
      Ano <= wc[F_ANO] ? nv : Ano;
      T_seg <= wt[F_TSEG] ? nv : T_seg;
      T_min <= wt[F_TMIN] ? nv : T_min;
      T_hora <= wt[F_THORA] ? nv : T_hora;
    end
  end
endmodule

// File: tb/tb_rtc_time_editor.sv
// tb_rtc_time_editor: randomized and directed checks of rtc_time_editor against a decimal field model
module tb_rtc_time_editor;
  localparam int DEB = 4, WRP = 4, TMO = 200;
  logic CLK = 1'b0, Reset = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_commit = 1'b0;
  logic CT = 1'b1, doce_24 = 1'b0;
  logic [7:0] clk_seg, clk_min, clk_hora, Dia, Mes, Ano, T_seg, T_min, T_hora;
  logic [2:0] cursor;
  logic edit_active, WR;
  int errors = 0, checks = 0;
  int mc[6];
  int mt[3];
  int mcur;
  bit medit, mdoce, mct;

  always #5 CLK = ~CLK;

  rtc_time_editor #(.DEB_CYC(DEB), .WR_PULSE_CYC(WRP), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .Reset(Reset), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_commit(btn_commit), .CT(CT), .doce_24(doce_24),
    .clk_seg(clk_seg), .clk_min(clk_min), .clk_hora(clk_hora), .Dia(Dia), .Mes(Mes), .Ano(Ano),
    .T_seg(T_seg), .T_min(T_min), .T_hora(T_hora), .cursor(cursor), .edit_active(edit_active), .WR(WR)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [76:0] dut_vec();
    return {clk_seg, clk_min, clk_hora, Dia, Mes, Ano, T_seg, T_min, T_hora, cursor, edit_active, WR};
  endfunction

  function automatic logic [76:0] model_vec();
    return {bcd(mc[0]), bcd(mc[1]), bcd(mc[2]), bcd(mc[3]), bcd(mc[4]), bcd(mc[5]),
            bcd(mt[0]), bcd(mt[1]), bcd(mt[2]), 3'(mcur), medit, 1'b0};
  endfunction

  function automatic int dia_lim();
`ifdef MONTH_DAYS_EN
    if (mc[4] == 2) return (mc[5] % 4 == 0) ? 29 : 28;
    if (mc[4] == 4 || mc[4] == 6 || mc[4] == 9 || mc[4] == 11) return 30;
`endif
    return 31;
  endfunction

  task automatic model_reset();
    mc = '{0, 0, 12, 1, 1, 0};
    mt = '{0, 0, 0};
    mcur = 0;
    medit = 0;
  endtask

  task automatic lim(input bit ct, input int f, output int lo, output int hi);
    lo = 0;
    hi = 59;
    if (ct && f == 2) begin lo = mdoce ? 1 : 0; hi = mdoce ? 12 : 23; end
    if (ct && f == 3) begin lo = 1; hi = dia_lim(); end
    if (ct && f == 4) begin lo = 1; hi = 12; end
    if (ct && f == 5) hi = 99;
    if (!ct && f == 2) hi = 23;
  endtask

  // m = {commit, right, left, down, up}
  task automatic model_press(input logic [4:0] m);
    int lo, hi, v, mx;
    bit u, d, l, r;
    if (!medit) begin
      if (m[3:0] != 4'd0) medit = 1;
      return;
    end
    if (m[4]) begin
      medit = 0;
      return;
    end
    u = m[0] && !m[1];
    d = m[1] && !m[0];
    l = m[2] && !m[3];
    r = m[3] && !m[2];
    mx = mct ? 5 : 2;
    if (u || d) begin
      lim(mct, mcur, lo, hi);
      v = mct ? mc[mcur] : mt[mcur];
      v = u ? ((v >= hi) ? lo : v + 1) : ((v <= lo) ? hi : v - 1);
      if (mct) mc[mcur] = v;
      else mt[mcur] = v;
    end
    if (r) mcur = (mcur == mx) ? 0 : mcur + 1;
    if (l) mcur = (mcur == 0) ? mx : mcur - 1;
    if (mc[3] > dia_lim()) mc[3] = dia_lim();
  endtask

  task automatic press(input logic [4:0] m);
    {btn_commit, btn_right, btn_left, btn_down, btn_up} = m;
    repeat (8) @(posedge CLK);
    #1;
    {btn_commit, btn_right, btn_left, btn_down, btn_up} = 5'd0;
    repeat (10) @(posedge CLK);
    #1;
    model_press(m);
  endtask

  task automatic set_doce(input bit b);
    if (b && !mdoce) mc[2] = (mc[2] == 0) ? 12 : (mc[2] > 12) ? mc[2] - 12 : mc[2];
    mdoce = b;
    doce_24 = b;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic set_ct(input bit b);
    if (b != mct) mcur = 0;
    mct = b;
    CT = b;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic goto_field(input int f);
    for (int i = 0; i < 6 && mcur != f; i++) press(5'b01000);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    Reset = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    if (dut_vec() !== model_vec()) begin errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
    if (clk_hora !== 8'h12) begin errors++; $display("FAIL reset_hora got=%h exp=12", clk_hora); end
    checks++;
  endtask

  task automatic test_debounce();
    press(5'b00001);
    if (dut_vec() !== model_vec()) begin errors++; $display("FAIL enter_edit got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
    btn_up = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    btn_up = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    if (dut_vec() !== model_vec()) begin errors++; $display("FAIL glitch got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
    btn_up = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    btn_up = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    model_press(5'b00001);
    if (clk_seg !== 8'h01 || dut_vec() !== model_vec()) begin errors++; $display("FAIL press6 got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
  endtask

  task automatic test_wrap();
    press(5'b00010);
    press(5'b00010);
    if (clk_seg !== 8'h59) begin errors++; $display("FAIL seg_wrap_down got=%h exp=59", clk_seg); end
    checks++;
    press(5'b00001);
    if (clk_seg !== 8'h00) begin errors++; $display("FAIL seg_wrap_up got=%h exp=00", clk_seg); end
    checks++;
    press(5'b00010);
    if (clk_seg !== 8'h59) begin errors++; $display("FAIL seg_59 got=%h exp=59", clk_seg); end
    checks++;
    press(5'b01000);
    repeat (9) press(5'b00001);
    press(5'b00001);
    if (clk_min !== 8'h10 || dut_vec() !== model_vec()) begin errors++; $display("FAIL min_carry got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
  endtask

  task automatic test_hour();
    goto_field(2);
    set_doce(1);
    press(5'b00001);
    if (clk_hora !== 8'h01) begin errors++; $display("FAIL hora12_wrap got=%h exp=01", clk_hora); end
    checks++;
    set_doce(0);
    press(5'b00010);
    press(5'b00010);
    if (clk_hora !== 8'h23) begin errors++; $display("FAIL hora24_wrap got=%h exp=23", clk_hora); end
    checks++;
    set_doce(1);
    if (clk_hora !== 8'h11 || dut_vec() !== model_vec()) begin errors++; $display("FAIL coerce_23 got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
    set_doce(0);
    repeat (11) press(5'b00010);
    set_doce(1);
    if (clk_hora !== 8'h12 || dut_vec() !== model_vec()) begin errors++; $display("FAIL coerce_00 got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
  endtask

  task automatic test_commit();
    logic [76:0] dv, mv;
    int wr_hi;
    bit moved;
    wr_hi = 0;
    moved = 0;
    mv = model_vec();
    btn_commit = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) btn_up = 1'b1;
      if (i == 10) {btn_commit, btn_up} = 2'b00;
      @(posedge CLK);
      #1;
      dv = dut_vec();
      if (WR) begin
        wr_hi++;
        if (dv[76:2] !== mv[76:2]) moved = 1;
      end
    end
    medit = 0;
    if (wr_hi != WRP) begin errors++; $display("FAIL wr_width got=%0d exp=%0d", wr_hi, WRP); end
    checks++;
    if (moved) begin errors++; $display("FAIL wr_fields_frozen got=changed exp=stable"); end
    checks++;
    if (dut_vec() !== model_vec()) begin errors++; $display("FAIL after_commit got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
  endtask

  task automatic test_cursor();
    press(5'b01000);
    goto_field(4);
    if (cursor !== 3'd4) begin errors++; $display("FAIL cursor4 got=%0d exp=4", cursor); end
    checks++;
    set_ct(0);
    if (cursor !== 3'd0 || dut_vec() !== model_vec()) begin errors++; $display("FAIL ct_toggle got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
    press(5'b01000);
    press(5'b01000);
    press(5'b01000);
    if (cursor !== 3'd0) begin errors++; $display("FAIL timer_right_wrap got=%0d exp=0", cursor); end
    checks++;
    press(5'b00100);
    if (cursor !== 3'd2) begin errors++; $display("FAIL timer_left_wrap got=%0d exp=2", cursor); end
    checks++;
    press(5'b00010);
    if (T_hora !== 8'h23 || dut_vec() !== model_vec()) begin errors++; $display("FAIL thora_wrap got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
    set_ct(1);
    if (dut_vec() !== model_vec()) begin errors++; $display("FAIL ct_back got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
  endtask

  task automatic test_simul();
    press(5'b00011);
    if (dut_vec() !== model_vec()) begin errors++; $display("FAIL up_down got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
    press(5'b01100);
    if (dut_vec() !== model_vec()) begin errors++; $display("FAIL left_right got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
    press(5'b01001);
    if (dut_vec() !== model_vec()) begin errors++; $display("FAIL up_right got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
    press(5'b10001);
    if (dut_vec() !== model_vec()) begin errors++; $display("FAIL commit_up got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
  endtask

`ifdef MONTH_DAYS_EN
  task automatic test_month();
    if (!medit) press(5'b01000);
    goto_field(5);
    for (int i = 0; i < 100 && mc[5] != 23; i++) press(5'b00001);
    goto_field(3);
    for (int i = 0; i < 40 && mc[3] != 31; i++) press(5'b00010);
    goto_field(4);
    for (int i = 0; i < 12 && mc[4] != 2; i++) press(5'b00001);
    if (Dia !== 8'h28 || dut_vec() !== model_vec()) begin errors++; $display("FAIL feb_clamp got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
    press(5'b01000);
    press(5'b00001);
    goto_field(3);
    press(5'b00001);
    if (Dia !== 8'h29) begin errors++; $display("FAIL leap_29 got=%h exp=29", Dia); end
    checks++;
    press(5'b00001);
    if (Dia !== 8'h01 || dut_vec() !== model_vec()) begin errors++; $display("FAIL leap_wrap got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
  endtask
`endif

  task automatic test_timeout();
    if (!medit) press(5'b00100);
    repeat (TMO + 20) @(posedge CLK);
    #1;
    medit = 0;
    if (edit_active !== 1'b0 || dut_vec() !== model_vec()) begin errors++; $display("FAIL timeout got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
  endtask

  task automatic test_random();
    logic [4:0] m;
    int r, a, b;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) set_doce(!mdoce);
      if (medit && $urandom_range(0, 11) == 0) set_ct(!mct);
      r = $urandom_range(0, 19);
      a = $urandom_range(0, 3);
      b = (a + $urandom_range(1, 3)) % 4;
      m = (r < 6) ? 5'b00001 : (r < 12) ? 5'b00010 : (r < 15) ? 5'b00100 : (r < 18) ? 5'b01000
        : (r == 18) ? 5'((1 << a) | (1 << b)) : 5'b10000;
      press(m);
      if (dut_vec() !== model_vec()) begin errors++; $display("FAIL random_%0d m=%b got=%h exp=%h", n, m, dut_vec(), model_vec()); end
      checks++;
    end
  endtask

  task automatic test_reset_commit();
    if (!medit) press(5'b01000);
    btn_commit = 1'b1;
    for (int i = 0; i < 40 && WR !== 1'b1; i++) begin
      @(posedge CLK);
      #1;
    end
    if (WR !== 1'b1) begin errors++; $display("FAIL wr_seen got=%b exp=1", WR); end
    checks++;
    Reset = 1'b0;
    @(posedge CLK);
    #1;
    if (WR !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b exp=0", WR); end
    checks++;
    btn_commit = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    if (dut_vec() !== model_vec()) begin errors++; $display("FAIL reset_after_abort got=%h exp=%h", dut_vec(), model_vec()); end
    checks++;
  endtask

  initial begin
    mct = 1;
    mdoce = 0;
    model_reset();
    test_reset();
    test_debounce();
    test_wrap();
    test_hour();
    test_commit();
    test_cursor();
    test_simul();
`ifdef MONTH_DAYS_EN
    test_month();
`endif
    test_timeout();
    test_random();
    test_reset_commit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
